// File: rtl/bcd2_counter_pkg.sv
// Shared constants and helpers for the two-digit BCD counter.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package bcd2_counter_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [1:0] AN_ONES = 2'b10;
  localparam logic [1:0] AN_TENS = 2'b01;
  localparam logic [1:0] AN_OFF  = 2'b11;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [3:0] bcd_clamp(
    input logic [3:0] d
  );
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd2_counter_if.sv
// Control and display bundle of the BCD counter.
// master = controller/observer side, slave = counter.
interface bcd2_counter_if;

  logic       bcd2_counter_tick;
  logic       bcd2_counter_en;
  logic       bcd2_counter_up;
  logic       bcd2_counter_clr;
  logic       bcd2_counter_load;
  logic [7:0] bcd2_counter_load_val;
  logic [3:0] bcd2_counter_ones;
  logic [3:0] bcd2_counter_tens;
  logic       bcd2_counter_wrap;
  logic [6:0] bcd2_counter_seg;
  logic [1:0] bcd2_counter_an;

  modport master (
    output bcd2_counter_tick,
    output bcd2_counter_en,
    output bcd2_counter_up,
    output bcd2_counter_clr,
    output bcd2_counter_load,
    output bcd2_counter_load_val,
    input  bcd2_counter_ones,
    input  bcd2_counter_tens,
    input  bcd2_counter_wrap,
    input  bcd2_counter_seg,
    input  bcd2_counter_an
  );

  modport slave (
    input  bcd2_counter_tick,
    input  bcd2_counter_en,
    input  bcd2_counter_up,
    input  bcd2_counter_clr,
    input  bcd2_counter_load,
    input  bcd2_counter_load_val,
    output bcd2_counter_ones,
    output bcd2_counter_tens,
    output bcd2_counter_wrap,
    output bcd2_counter_seg,
    output bcd2_counter_an
  );

endinterface

// File: rtl/bcd2_counter_seg7_decoder.sv
// BCD digit to active-low 7-segment pattern.
// Non-BCD codes produce a blank digit.
module seg7_decoder
  import bcd2_counter_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd2_counter.sv
// Two-digit BCD up/down counter with multiplexed 7-seg driver.
// Option: BCD2_COUNTER_LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module bcd2_counter
  import bcd2_counter_pkg::*;
#(
  parameter int SCAN_BITS = 18
) (
  input logic          bcd2_counter_fsys,
  input logic          bcd2_counter_rst,
  bcd2_counter_if.slave bus
);

  logic                 r_tick_d;
  logic [3:0]           r_ones;
  logic [3:0]           r_tens;
  logic                 r_wrap;
  logic [SCAN_BITS-1:0] r_scan;
  logic [6:0]           r_seg;
  logic [1:0]           r_an;

  logic       w_evt;
  logic [3:0] w_ones_nx;
  logic [3:0] w_tens_nx;
  logic       w_wrap_nx;
  logic       w_sel;
  logic [3:0] w_digit;
  logic [6:0] w_dec;
  logic [6:0] w_seg_nx;
  logic [1:0] w_an_nx;

  // tick is a level from the divider; count its rising edge only
  assign w_evt = bus.bcd2_counter_tick
               & ~r_tick_d
               & bus.bcd2_counter_en;

  always_comb begin
    w_ones_nx = r_ones;
    w_tens_nx = r_tens;
    w_wrap_nx = 1'b0;
    priority case (1'b1)
      bus.bcd2_counter_clr: begin
        w_ones_nx = 4'd0;
        w_tens_nx = 4'd0;
      end
      bus.bcd2_counter_load: begin
        w_ones_nx = bcd_clamp(bus.bcd2_counter_load_val[3:0]);
        w_tens_nx = bcd_clamp(bus.bcd2_counter_load_val[7:4]);
      end
      w_evt: begin
        if (bus.bcd2_counter_up) begin
          if (r_ones == BCD_MAX) begin
            w_ones_nx = 4'd0;
            if (r_tens == BCD_MAX) begin
              w_tens_nx = 4'd0;
              w_wrap_nx = 1'b1;
            end else begin
              w_tens_nx = r_tens + 4'd1;
            end
          end else begin
            w_ones_nx = r_ones + 4'd1;
          end
        end else begin
          if (r_ones == 4'd0) begin
            w_ones_nx = BCD_MAX;
            if (r_tens == 4'd0) begin
              w_tens_nx = BCD_MAX;
              w_wrap_nx = 1'b1;
            end else begin
              w_tens_nx = r_tens - 4'd1;
            end
          end else begin
            w_ones_nx = r_ones - 4'd1;
          end
        end
      end
      default: ;
    endcase
  end

  assign w_sel   = r_scan[SCAN_BITS-1];
  assign w_digit = w_sel ? r_tens : r_ones;

  seg7_decoder u_dec (
    .i_bcd (w_digit),
    .o_seg (w_dec)
  );

  always_comb begin
    w_an_nx  = w_sel ? AN_TENS : AN_ONES;
    w_seg_nx = w_dec;
`ifdef BCD2_COUNTER_LEADING_ZERO_BLANK_EN
    if (w_sel && (r_tens == 4'd0)) begin
      w_an_nx  = AN_OFF;
      w_seg_nx = SEG_BLANK;
    end
`endif
  end

  always_ff @(posedge bcd2_counter_fsys) begin
    if (bcd2_counter_rst) begin
      r_tick_d <= 1'b0;
      r_ones   <= 4'd0;
      r_tens   <= 4'd0;
      r_wrap   <= 1'b0;
      r_scan   <= '0;
      r_seg    <= SEG_BLANK;
      r_an     <= AN_OFF;
    end else begin
      r_tick_d <= bus.bcd2_counter_tick;
      r_ones   <= w_ones_nx;
      r_tens   <= w_tens_nx;
      r_wrap   <= w_wrap_nx;
      r_scan   <= r_scan + 1'b1;
      r_seg    <= w_seg_nx;
      r_an     <= w_an_nx;
    end
  end

  assign bus.bcd2_counter_ones = r_ones;
  assign bus.bcd2_counter_tens = r_tens;
  assign bus.bcd2_counter_wrap = r_wrap;
  assign bus.bcd2_counter_seg  = r_seg;
  assign bus.bcd2_counter_an   = r_an;

endmodule

// File: tb/tb_bcd2_counter.sv
// Directed bench for bcd2_counter (SCAN_BITS=3).
// Honors BCD2_COUNTER_LEADING_ZERO_BLANK_EN for display expectations.
module tb_bcd2_counter;

  logic clk = 1'b0;
  logic rst;

  bcd2_counter_if bus ();

  bcd2_counter #(
    .SCAN_BITS (3)
  ) dut (
    .bcd2_counter_fsys (clk),
    .bcd2_counter_rst  (rst),
    .bus               (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       load;
    logic [7:0] lv;
    logic       tick;
    logic       en;
    logic       up;
    logic [7:0] exp;
    logic       ew;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  function automatic vec_t v(
    input logic       clr,
    input logic       load,
    input logic [7:0] lv,
    input logic       tick,
    input logic       en,
    input logic       up,
    input logic [7:0] exp,
    input logic       ew
  );
    vec_t r;
    r.clr  = clr;
    r.load = load;
    r.lv   = lv;
    r.tick = tick;
    r.en   = en;
    r.up   = up;
    r.exp  = exp;
    r.ew   = ew;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string nm,
    input int    act,
    input int    exp
  );
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_val(
    input string      nm,
    input logic [7:0] exp,
    input logic       ew
  );
    chk({nm, " value"},
        {bus.bcd2_counter_tens, bus.bcd2_counter_ones}, exp);
    chk({nm, " wrap"}, bus.bcd2_counter_wrap, ew);
  endtask

  task automatic drive(
    input logic       clr,
    input logic       load,
    input logic [7:0] lv,
    input logic       tick,
    input logic       en,
    input logic       up
  );
    bus.bcd2_counter_clr      = clr;
    bus.bcd2_counter_load     = load;
    bus.bcd2_counter_load_val = lv;
    bus.bcd2_counter_tick     = tick;
    bus.bcd2_counter_en       = en;
    bus.bcd2_counter_up       = up;
  endtask

  vec_t tbl[$];

  initial begin
    tbl.push_back(v(0, 0, 8'h00, 1, 1, 1, 8'h01, 0));
    tbl.push_back(v(0, 0, 8'h00, 0, 1, 1, 8'h01, 0));
    tbl.push_back(v(0, 1, 8'h98, 0, 1, 1, 8'h98, 0));
    tbl.push_back(v(0, 0, 8'h00, 1, 1, 1, 8'h99, 0));
    tbl.push_back(v(0, 0, 8'h00, 0, 1, 1, 8'h99, 0));
    tbl.push_back(v(0, 0, 8'h00, 1, 1, 1, 8'h00, 1));
    tbl.push_back(v(0, 0, 8'h00, 0, 1, 1, 8'h00, 0));
    tbl.push_back(v(0, 0, 8'h00, 1, 1, 0, 8'h99, 1));
    tbl.push_back(v(0, 0, 8'h00, 0, 1, 0, 8'h99, 0));
    tbl.push_back(v(0, 0, 8'h00, 1, 1, 0, 8'h98, 0));
    tbl.push_back(v(0, 0, 8'h00, 0, 1, 0, 8'h98, 0));
    tbl.push_back(v(0, 1, 8'hAF, 0, 1, 0, 8'h99, 0));
    tbl.push_back(v(1, 1, 8'h55, 1, 1, 1, 8'h00, 0));
    tbl.push_back(v(0, 0, 8'h00, 1, 1, 1, 8'h00, 0));
    tbl.push_back(v(0, 0, 8'h00, 0, 1, 1, 8'h00, 0));
    tbl.push_back(v(0, 0, 8'h00, 1, 0, 1, 8'h00, 0));
    tbl.push_back(v(0, 0, 8'h00, 0, 0, 0, 8'h00, 0));
    tbl.push_back(v(0, 0, 8'h00, 1, 1, 1, 8'h01, 0));
    tbl.push_back(v(0, 1, 8'hA3, 0, 1, 1, 8'h93, 0));
    tbl.push_back(v(0, 0, 8'h00, 1, 1, 0, 8'h92, 0));
    tbl.push_back(v(0, 0, 8'h00, 0, 1, 0, 8'h92, 0));
    tbl.push_back(v(0, 1, 8'h19, 0, 1, 1, 8'h19, 0));
    tbl.push_back(v(0, 0, 8'h00, 1, 1, 1, 8'h20, 0));
    tbl.push_back(v(0, 0, 8'h00, 0, 1, 0, 8'h20, 0));
    tbl.push_back(v(0, 0, 8'h00, 1, 1, 0, 8'h19, 0));
    tbl.push_back(v(0, 0, 8'h00, 0, 1, 1, 8'h19, 0));
    tbl.push_back(v(0, 1, 8'h42, 1, 1, 1, 8'h42, 0));
    tbl.push_back(v(0, 0, 8'h00, 1, 1, 1, 8'h42, 0));

    rst = 1'b1;
    drive(0, 0, 8'h00, 0, 0, 0);
    step();
    step();
    chk_val("reset", 8'h00, 0);
    chk("reset an", bus.bcd2_counter_an, 2'b11);
    chk("reset seg", bus.bcd2_counter_seg, 7'h7F);

    rst = 1'b0;
    foreach (tbl[i]) begin
      drive(tbl[i].clr, tbl[i].load, tbl[i].lv,
            tbl[i].tick, tbl[i].en, tbl[i].up);
      step();
      chk_val($sformatf("vec%0d", i), tbl[i].exp, tbl[i].ew);
    end

    // tick held high for 10 cycles counts once
    drive(0, 0, 8'h00, 0, 1, 1);
    step();
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 8'h00, 1, 1, 1);
      step();
      if (i == 0) chk_val("held first", 8'h43, 1'b0);
    end
    chk_val("held end", 8'h43, 1'b0);

    // en low: five rising edges ignored
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 8'h00, 0, 0, 1);
      step();
      drive(0, 0, 8'h00, 1, 0, 1);
      step();
    end
    chk_val("en low", 8'h43, 1'b0);

    // reset mid-count with a pending count edge
    drive(0, 1, 8'h57, 0, 1, 1);
    step();
    chk_val("load57", 8'h57, 1'b0);
    rst = 1'b1;
    drive(0, 0, 8'h00, 1, 1, 1);
    step();
    chk_val("rst57", 8'h00, 1'b0);
    chk("rst57 an", bus.bcd2_counter_an, 2'b11);
    chk("rst57 seg", bus.bcd2_counter_seg, 7'h7F);

    // reset on a would-be down wrap suppresses wrap
    rst = 1'b0;
    drive(0, 0, 8'h00, 0, 1, 0);
    step();
    rst = 1'b1;
    drive(0, 0, 8'h00, 1, 1, 0);
    step();
    chk_val("rst wrap", 8'h00, 1'b0);
    step();
    chk_val("rst wrap+1", 8'h00, 1'b0);

    // digit scan: edge k uses scan = (k-1) mod 8
    rst = 1'b0;
    drive(0, 1, 8'h07, 0, 0, 1);
    step();
    drive(0, 0, 8'h00, 0, 0, 1);
    for (int k = 2; k < 18; k++) begin
      logic       ph;
      logic [1:0] ea;
      logic [6:0] es;
      step();
      ph = (((k - 1) % 8) >= 4);
      if (ph) begin
`ifdef BCD2_COUNTER_LEADING_ZERO_BLANK_EN
        ea = 2'b11;
        es = 7'h7F;
`else
        ea = 2'b01;
        es = 7'h40;
`endif
      end else begin
        ea = 2'b10;
        es = 7'h78;
      end
      chk($sformatf("scan an k%0d", k), bus.bcd2_counter_an, ea);
      chk($sformatf("scan seg k%0d", k), bus.bcd2_counter_seg, es);
    end
    chk_val("scan value", 8'h07, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
